dht11_receiver: RTL and testbench

Decodes the 40-bit DHT11 data frame that follows the start/response handshake. Sits directly downstream of the start-signal sequencer: it arms when that stage's confirm output rises, samples the bidirectional data line (input side only), measures each bit's high-pulse width, verifies the checksum and presents humidity/temperature bytes with a one-cycle valid strobe. The design clock is 1 MHz, so one cycle equals 1 µs and all timing parameters are given in cycles.

---
 rtl/dht11_pkg.sv | 32 +++
 rtl/dht11_line_sync.sv | 32 +++
 rtl/dht11_receiver.sv | 160 ++++++++++++++++
 tb/tb_dht11_receiver.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dht11_pkg.sv
// Shared DHT11 definitions: receiver state encoding, frame geometry, default timing
// constants (also used by the start-signal sequencer) and the frame checksum.
package dht11_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_LOW,
        ST_LOW,
        ST_HIGH,
        ST_CHECK
    } dht11_state_e;

    localparam int unsigned DHT11_FRAME_BITS    = 40;
    localparam int unsigned DHT11_BIT_THRESHOLD = 50;
    localparam int unsigned DHT11_TIMEOUT       = 200;
    localparam int unsigned DHT11_START_LOW     = 18000;
    localparam int unsigned DHT11_RESPONSE_LVL  = 80;

    // Payload bytes in wire order (first byte received is the MSB).
    typedef struct packed {
        logic [7:0] hum_int;
        logic [7:0] hum_dec;
        logic [7:0] temp_int;
        logic [7:0] temp_dec;
    } dht11_reading_t;

    // 8-bit wrapping sum of the four payload bytes.
    function automatic logic [7:0] dht11_checksum(input logic [31:0] payload);
        dht11_checksum = payload[31:24] + payload[23:16] + payload[15:8] + payload[7:0];
    endfunction

endpackage

// File: rtl/dht11_line_sync.sv
// Brings the asynchronous DHT11 data line into the clock domain and flags its edges.
// Flops reset high (the line idles high on its pull-up) so reset release creates no edge.
module dht11_line_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic line_i,
    output logic line_o,
    output logic rise_o,
    output logic fall_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign line_o = sync2_q;
    assign rise_o = sync2_q & ~prev_q;
    assign fall_o = ~sync2_q & prev_q;

endmodule

// File: rtl/dht11_receiver.sv
// DHT11 40-bit frame decoder: measures each bit's high-pulse width, assembles the frame
// MSB-first, verifies the checksum and presents the reading with one-cycle status strobes.
module dht11_receiver
    import dht11_pkg::*;
#(
    parameter int unsigned BIT_THRESHOLD = DHT11_BIT_THRESHOLD,
    parameter int unsigned TIMEOUT       = DHT11_TIMEOUT
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       dht_in_i,
    output logic [7:0] humidity_int_o,
    output logic [7:0] humidity_dec_o,
    output logic [7:0] temp_int_o,
    output logic [7:0] temp_dec_o,
    output logic       data_valid_o,
    output logic       checksum_err_o,
    output logic       timeout_err_o,
    output logic       busy_o
);

    localparam int unsigned CNT_W     = $clog2(TIMEOUT + 1);
    localparam int unsigned BIT_CNT_W = $clog2(DHT11_FRAME_BITS);
    localparam logic [CNT_W-1:0]     CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DHT11_FRAME_BITS - 1);

    logic line_unused_c;
    logic rise_c;
    logic fall_c;

    dht11_line_sync u_line_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .line_i (dht_in_i),
        .line_o (line_unused_c),
        .rise_o (rise_c),
        .fall_o (fall_c)
    );

    dht11_state_e                state_q;
    logic                        start_q;
    logic [CNT_W-1:0]            cnt_q;
    logic [BIT_CNT_W-1:0]        bit_cnt_q;
    logic [DHT11_FRAME_BITS-1:0] shift_q;
    dht11_reading_t              reading_q;
    logic                        data_valid_q;
    logic                        checksum_err_q;
    logic                        timeout_err_q;
    logic                        busy_q;

    logic                        start_rise_c;
    logic [CNT_W-1:0]            cnt_inc_c;
    logic [CNT_W:0]              hi_width_c;
    logic                        bit_c;
    logic [DHT11_FRAME_BITS-1:0] frame_c;
    logic                        frame_ok_c;

    assign start_rise_c = start_i & ~start_q;
    assign cnt_inc_c    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    // The falling-edge cycle itself is part of the high phase, hence the +1.
    assign hi_width_c = {1'b0, cnt_q} + (CNT_W + 1)'(1);
    assign bit_c      = hi_width_c > (CNT_W + 1)'(BIT_THRESHOLD);
    assign frame_c    = {shift_q[DHT11_FRAME_BITS-2:0], bit_c};
    assign frame_ok_c = frame_c[7:0] == dht11_checksum(frame_c[DHT11_FRAME_BITS-1:8]);

    // Frame FSM; the verdict is registered on the 40th falling edge so the status strobe
    // and the output update coincide with the single CHECK cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ST_IDLE;
            start_q        <= 1'b0;
            cnt_q          <= '0;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            reading_q      <= '0;
            data_valid_q   <= 1'b0;
            checksum_err_q <= 1'b0;
            timeout_err_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            start_q        <= start_i;
            data_valid_q   <= 1'b0;
            checksum_err_q <= 1'b0;
            timeout_err_q  <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    busy_q    <= 1'b0;
                    cnt_q     <= '0;
                    bit_cnt_q <= '0;
                    shift_q   <= '0;
                    if (start_rise_c) begin
                        state_q <= ST_WAIT_LOW;
                        busy_q  <= 1'b1;
                    end
                end

                ST_WAIT_LOW, ST_LOW: begin
                    if ((state_q == ST_WAIT_LOW) ? fall_c : rise_c) begin
                        cnt_q   <= '0;
                        state_q <= (state_q == ST_WAIT_LOW) ? ST_LOW : ST_HIGH;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q       <= ST_IDLE;
                        busy_q        <= 1'b0;
                        timeout_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_inc_c;
                    end
                end

                ST_HIGH: begin
                    if (fall_c) begin
                        shift_q   <= frame_c;
                        bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
                        cnt_q     <= '0;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q <= ST_CHECK;
                            if (frame_ok_c) begin
                                reading_q    <= dht11_reading_t'(frame_c[DHT11_FRAME_BITS-1:8]);
                                data_valid_q <= 1'b1;
                            end else begin
                                checksum_err_q <= 1'b1;
                            end
                        end else begin
                            state_q <= ST_LOW;
                        end
                    end else if (cnt_q == CNT_MAX) begin
                        state_q       <= ST_IDLE;
                        busy_q        <= 1'b0;
                        timeout_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_inc_c;
                    end
                end

                ST_CHECK: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign humidity_int_o = reading_q.hum_int;
    assign humidity_dec_o = reading_q.hum_dec;
    assign temp_int_o     = reading_q.temp_int;
    assign temp_dec_o     = reading_q.temp_dec;
    assign data_valid_o   = data_valid_q;
    assign checksum_err_o = checksum_err_q;
    assign timeout_err_o  = timeout_err_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_dht11_receiver.sv
// Bench for dht11_receiver: drives DHT11-shaped frames and checks the outputs every cycle
// against a width-based frame model, plus literal expectations per scenario.
`timescale 1ns/1ps
module tb_dht11_receiver;
    import dht11_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       dht;
    logic [7:0] hum_int, hum_dec, t_int, t_dec;
    logic       dv, ce, to, busy;

    dht11_receiver dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .dht_in_i       (dht),
        .humidity_int_o (hum_int),
        .humidity_dec_o (hum_dec),
        .temp_int_o     (t_int),
        .temp_dec_o     (t_dec),
        .data_valid_o   (dv),
        .checksum_err_o (ce),
        .timeout_err_o  (to),
        .busy_o         (busy)
    );

    always #500 clk = ~clk;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] held   = '0;
    logic [31:0] pend   = '0;
    bit          pend_good = 1'b0;
    int          n_dv = 0, n_ce = 0, n_to = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle output check, run 1 time unit after every active edge.
    task automatic monitor();
        int hot;
        hot = int'(dv) + int'(ce) + int'(to);
        check("status_onehot", 32'(hot <= 1), 32'd1);
        if (!rst_n) held = '0;
        if (dv) begin
            n_dv++;
            check("dv_expected", 32'(pend_good), 32'd1);
            held = pend;
        end
        if (ce) n_ce++;
        if (to) n_to++;
        check("outputs", {hum_int, hum_dec, t_int, t_dec}, held);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        monitor();
    endtask

    // Model: a bit is 1 iff its high phase exceeds the threshold; checksum is a wrapping byte sum.
    task automatic decode(input int w[40], output logic [39:0] f, output bit good);
        int s;
        for (int i = 0; i < 40; i++) f[39-i] = (w[i] > int'(DHT11_BIT_THRESHOLD));
        s = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
        good = ((s % 256) == int'(f[7:0]));
    endtask

    task automatic make_widths(input logic [39:0] f, output int w[40]);
        for (int i = 0; i < 40; i++) w[i] = f[39-i] ? 70 : 27;
    endtask

    task automatic arm();
        dht   = 1'b1;
        start = 1'b1;
        repeat (80) tick();
    endtask

    task automatic send_bit(input int w);
        dht = 1'b0;
        repeat (50) tick();
        dht = 1'b1;
        repeat (w) tick();
    endtask

    task automatic frame_end();
        dht = 1'b0;
        repeat (50) tick();
        dht = 1'b1;
        repeat (20) tick();
        start = 1'b0;
        repeat (10) tick();
    endtask

    // Full frame; glitch_at >= 0 drops and re-raises start just before that bit.
    task automatic run_frame(input string name, input int w[40], input int glitch_at);
        logic [39:0] f;
        bit          good;
        int          dv0, ce0, to0;
        decode(w, f, good);
        pend = f[39:8];
        pend_good = good;
        dv0 = n_dv; ce0 = n_ce; to0 = n_to;
        arm();
        check({name, "_busy_armed"}, 32'(busy), 32'd1);
        for (int i = 0; i < 40; i++) begin
            if (i == glitch_at) begin
                start = 1'b0;
                repeat (3) tick();
                start = 1'b1;
            end
            send_bit(w[i]);
        end
        frame_end();
        check({name, "_dv_count"}, 32'(n_dv - dv0), good ? 32'd1 : 32'd0);
        check({name, "_ce_count"}, 32'(n_ce - ce0), good ? 32'd0 : 32'd1);
        check({name, "_to_count"}, 32'(n_to - to0), 32'd0);
        check({name, "_busy_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int          w[40];
        logic [39:0] f;
        bit          good;
        int          dv0, ce0, to0, k_to;

        rst_n = 1'b1;
        start = 1'b0;
        dht   = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        check("reset_outputs", {hum_int, hum_dec, t_int, t_dec}, 32'h0);
        check("reset_status", {29'd0, dv, ce, to}, 32'h0);
        check("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (5) tick();

        // Nominal frame
        make_widths(40'h37_00_18_00_4F, w);
        decode(w, f, good);
        check("model_A_good", 32'(good), 32'd1);
        run_frame("frameA", w, -1);
        check("A_hum_int", 32'(hum_int), 32'h37);
        check("A_temp_int", 32'(t_int), 32'h18);
        check("A_decimals", {hum_dec, t_dec}, 32'h0);

        // Bad checksum: outputs hold
        make_widths(40'h37_00_18_00_50, w);
        decode(w, f, good);
        check("model_B_bad", 32'(good), 32'd0);
        run_frame("frameB", w, -1);
        check("B_held", {hum_int, hum_dec, t_int, t_dec}, 32'h37_00_18_00);

        // Wrapping checksum
        make_widths(40'hFF_FF_FF_FF_FC, w);
        run_frame("frameFF", w, -1);
        check("FF_outputs", {hum_int, hum_dec, t_int, t_dec}, 32'hFFFF_FFFF);

        // Threshold boundary: 50 -> 0, 51 -> 1
        make_widths(40'h01_00_00_00_01, w);
        w[6] = 50; w[7] = 51; w[38] = 50; w[39] = 51;
        decode(w, f, good);
        check("model_bnd_frame", f[39:8], 32'h01_00_00_00);
        run_frame("boundary", w, -1);
        check("bnd_outputs", {hum_int, hum_dec, t_int, t_dec}, 32'h01_00_00_00);

        // Timeout: line stuck high after 10 bits
        make_widths(40'h37_00_18_00_4F, w);
        pend_good = 1'b0;
        dv0 = n_dv; ce0 = n_ce; to0 = n_to;
        arm();
        for (int i = 0; i < 10; i++) send_bit(w[i]);
        dht = 1'b0;
        repeat (50) tick();
        dht = 1'b1;
        k_to = -1;
        for (int k = 1; k <= 400; k++) begin
            tick();
            if (to && k_to < 0) k_to = k;
            if (k_to >= 0) break;
        end
        check("to_latency_window", 32'(k_to >= 200 && k_to <= 206), 32'd1);
        check("to_count", 32'(n_to - to0), 32'd1);
        check("to_no_other", 32'((n_dv - dv0) + (n_ce - ce0)), 32'd0);
        check("to_busy_low", 32'(busy), 32'd0);
        check("to_outputs_kept", {hum_int, hum_dec, t_int, t_dec}, 32'h01_00_00_00);
        start = 1'b0;
        repeat (10) tick();

        // Mid-frame start edge must not disturb the frame
        make_widths(40'h40_05_1A_03_62, w);
        run_frame("glitch", w, 12);
        check("glitch_outputs", {hum_int, hum_dec, t_int, t_dec}, 32'h40_05_1A_03);

        // Start edge mid-frame, then reset at bit 20
        make_widths(40'h37_00_18_00_4F, w);
        pend_good = 1'b0;
        dv0 = n_dv; ce0 = n_ce; to0 = n_to;
        arm();
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                start = 1'b0;
                repeat (3) tick();
                start = 1'b1;
            end
            send_bit(w[i]);
        end
        check("pre_rst_busy", 32'(busy), 32'd1);
        #200 rst_n = 1'b0;
        #1;
        check("rst_async_outputs", {hum_int, hum_dec, t_int, t_dec}, 32'h0);
        check("rst_async_busy", 32'(busy), 32'd0);
        held  = '0;
        start = 1'b0;
        dht   = 1'b1;
        repeat (5) tick();
        rst_n = 1'b1;
        repeat (300) tick();
        check("rst_no_pulses", 32'((n_dv - dv0) + (n_ce - ce0) + (n_to - to0)), 32'd0);
        check("rst_busy_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
